// File: rtl/inv_sweep_ctrl_if.sv
// Handshake, stimulus and log bundle between the sweep controller and its bench/scheduler.
interface inv_sweep_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] y_in;
  logic [WIDTH-1:0] a_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH:0]   err_count;
  logic             log_valid;
  logic [WIDTH-1:0] log_a;
  logic [WIDTH-1:0] log_y;

  modport slave (
    input  start, y_in,
    output a_out, busy, done, pass, err_count, log_valid, log_a, log_y
  );

  modport master (
    output start, y_in,
    input  a_out, busy, done, pass, err_count, log_valid, log_a, log_y
  );
endinterface

// File: rtl/inv_sweep_ctrl.sv
// Exhaustive inverter-bank sweep with settle delay, mismatch counting and per-pattern logging.
// Optional INV_SWEEP_STOP_ON_FAIL_EN ends the run at the first mismatching pattern.
module inv_sweep_ctrl #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic           clk,
  input  logic           rst,
  inv_sweep_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t         state;
  logic [3:0]     cnt;
  logic           mismatch;
  logic           last;
  logic           finish;
  logic [WIDTH:0] err_inc;

  always_comb begin
    mismatch = (bus.y_in != ~bus.a_out);
    last     = (bus.a_out == {WIDTH{1'b1}});
    err_inc  = bus.err_count + {{WIDTH{1'b0}}, mismatch};
`ifdef INV_SWEEP_STOP_ON_FAIL_EN
    finish   = last || mismatch;
`else
    finish   = last;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      bus.a_out     <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.pass      <= 1'b0;
      bus.err_count <= '0;
      bus.log_valid <= 1'b0;
      bus.log_a     <= '0;
      bus.log_y     <= '0;
    end else begin
      bus.log_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state         <= ST_SETTLE;
            cnt           <= '0;
            bus.a_out     <= '0;
            bus.err_count <= '0;
            bus.pass      <= 1'b0;
            bus.busy      <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state <= ST_SAMPLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_SAMPLE: begin
          bus.log_valid <= 1'b1;
          bus.log_a     <= bus.a_out;
          bus.log_y     <= bus.y_in;
          bus.err_count <= err_inc;
          // pass is registered from the post-increment count so it is valid with done
          if (finish) begin
            state    <= ST_DONE;
            bus.done <= 1'b1;
            bus.pass <= (err_inc == '0);
          end else begin
            state     <= ST_SETTLE;
            cnt       <= '0;
            bus.a_out <= bus.a_out + {{(WIDTH-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
`ifdef INV_SWEEP_STOP_ON_FAIL_EN
          bus.a_out <= '0;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
